mnist_fb_arbiter: RTL

- Single-port arbiter for the 28x28 8-bit MNIST image RAM.
- Serves three requesters: the VGA pixel prefetcher (real-time), the image loader (camera/HPS writes) and the inference accelerator (reads).
- Guarantees bounded wait for every requester.
- Protects image coherence during inference, and flags when a complete image has been loaded.

---
 rtl/mnist_fb_pkg.sv | 20 ++
 rtl/fb_starve_cnt.sv | 38 +++
 rtl/mnist_fb_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mnist_fb_pkg.sv
// Shared definitions for the MNIST image frame buffer and its clients
// (loader, VGA prefetcher, inference accelerator).
//   ADDR_W / DATA_W / IMG_WORDS : image RAM geometry (28x28 8-bit pixels)
//   STARVE_MAX                  : losing cycles before a requester is forced
//   req_id_e                    : requester identity used for grants and read tags
package mnist_fb_pkg;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 8;
    localparam int IMG_WORDS  = 784;
    localparam int STARVE_MAX = 15;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_VGA,
        REQ_LD,
        REQ_ACC
    } req_id_e;

endpackage

// File: rtl/fb_starve_cnt.sv
// Saturating starvation counter for one arbiter requester.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : requester lost arbitration this cycle
//   clr        : requester was granted, dropped its request or went ineligible
//   sat        : counter has reached MAX (registered; drives the forced grant)
module fb_starve_cnt #(
    parameter int MAX   = 15,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_W'(MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == CNT_W'(MAX));

endmodule

// File: rtl/mnist_fb_arbiter.sv
// Single-port arbiter for the 28x28 MNIST image RAM.
//   vga_*      : real-time VGA prefetch reads (req/addr in, gnt/rvalid out)
//   ld_*       : image loader writes (req/addr/wdata in, gnt out)
//   acc_*      : inference accelerator reads (req/addr in, gnt/rvalid out)
//   acc_lock   : inference running, loader writes are held off
//   rdata      : registered RAM read data shared by both readers
//   image_ready: last pixel of an image has been written
//   ram_*      : single-port RAM interface, read data one cycle after ram_en
// Priority: forced (starved ld/acc) > VGA > round-robin ld/acc.
module mnist_fb_arbiter #(
    parameter int ADDR_W     = mnist_fb_pkg::ADDR_W,
    parameter int DATA_W     = mnist_fb_pkg::DATA_W,
    parameter int IMG_WORDS  = mnist_fb_pkg::IMG_WORDS,
    parameter int STARVE_MAX = mnist_fb_pkg::STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    input  logic              acc_req,
    input  logic [ADDR_W-1:0] acc_addr,
    output logic              acc_gnt,
    output logic              acc_rvalid,
    input  logic              acc_lock,
    output logic [DATA_W-1:0] rdata,
    output logic              image_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    import mnist_fb_pkg::*;

    req_id_e           win;
    req_id_e           rr_last_d, rr_last_q;
    req_id_e           tag1_d, tag1_q;   // read owner, RAM data arriving this cycle
    req_id_e           tag2_d, tag2_q;   // read owner, rdata valid this cycle
    logic [DATA_W-1:0] rdata_d, rdata_q;
    logic              image_ready_d, image_ready_q;
    logic              ld_elig, ld_sat, acc_sat, ld_force, acc_force;
    logic              rr_pick_acc;

    assign ld_elig   = ld_req & ~acc_lock;
    // Forced checks use only the registered saturation flag, so req has no
    // combinational path back into the counters.
    assign ld_force  = ld_sat & ld_elig;
    assign acc_force = acc_sat & acc_req;
    assign rr_pick_acc = (rr_last_q == REQ_LD);

    always_comb begin
        win = REQ_NONE;
        if (!rst_n) begin
            win = REQ_NONE;  // keep every strobe low while held in reset
        end else if (ld_force && acc_force) begin
            win = rr_pick_acc ? REQ_ACC : REQ_LD;
        end else if (ld_force) begin
            win = REQ_LD;
        end else if (acc_force) begin
            win = REQ_ACC;
        end else if (vga_req) begin
            win = REQ_VGA;
        end else if (ld_elig && acc_req) begin
            win = rr_pick_acc ? REQ_ACC : REQ_LD;
        end else if (ld_elig) begin
            win = REQ_LD;
        end else if (acc_req) begin
            win = REQ_ACC;
        end
    end

    assign vga_gnt = (win == REQ_VGA);
    assign ld_gnt  = (win == REQ_LD);
    assign acc_gnt = (win == REQ_ACC);
    assign ram_en  = (win != REQ_NONE);
    assign ram_we  = ld_gnt;

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        case (win)
            REQ_VGA: ram_addr = vga_addr;
            REQ_LD: begin
                ram_addr  = ld_addr;
                ram_wdata = ld_wdata;
            end
            REQ_ACC: ram_addr = acc_addr;
            default: ;
        endcase
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (ld_gnt || acc_gnt) begin
            rr_last_d = win;
        end
        tag1_d = (vga_gnt || acc_gnt) ? win : REQ_NONE;
        tag2_d = tag1_q;
        rdata_d = (tag1_q != REQ_NONE) ? ram_rdata : rdata_q;
        image_ready_d = image_ready_q;
        // Set is checked last so it wins when IMG_WORDS = 1.
        if (ld_gnt && (ld_addr == '0)) begin
            image_ready_d = 1'b0;
        end
        if (ld_gnt && (ld_addr == ADDR_W'(IMG_WORDS - 1))) begin
            image_ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q     <= REQ_ACC;
            tag1_q        <= REQ_NONE;
            tag2_q        <= REQ_NONE;
            rdata_q       <= '0;
            image_ready_q <= 1'b0;
        end else begin
            rr_last_q     <= rr_last_d;
            tag1_q        <= tag1_d;
            tag2_q        <= tag2_d;
            rdata_q       <= rdata_d;
            image_ready_q <= image_ready_d;
        end
    end

    assign vga_rvalid  = (tag2_q == REQ_VGA);
    assign acc_rvalid  = (tag2_q == REQ_ACC);
    assign rdata       = rdata_q;
    assign image_ready = image_ready_q;

    // Loader counter also clears while locked out so it resumes from zero.
    fb_starve_cnt #(.MAX(STARVE_MAX)) u_ld_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ld_elig & ~ld_gnt),
        .clr   (~ld_elig | ld_gnt),
        .sat   (ld_sat)
    );

    fb_starve_cnt #(.MAX(STARVE_MAX)) u_acc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (acc_req & ~acc_gnt),
        .clr   (~acc_req | acc_gnt),
        .sat   (acc_sat)
    );

endmodule
